conv_feeder: RTL
================

# conv_feeder

- Streaming source for the `conv` datapath: reads a signed 8-bit feature map from a 32-bit-word SRAM and emits 4-lane words with a valid/ready handshake.
- Word order fills the convolution's 3-row shift register: for each 3×4 window, the bottom row is sent first and the top row last.
- Windows step 2 bytes horizontally (two 3×3 outputs per window) and 1 row vertically.
- Unaligned windows are assembled from two SRAM words.

## Interface
- `IMG_W`, default 16: row width in bytes; multiple of 4, ≥4.
- `IMG_H`, default 16: image height in rows; ≥3.
- `ADDR_W`, default 16: SRAM byte-address width.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  byte address of pixel (0,0); 4-aligned; latched on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `mem_en`  out  1  SRAM read strobe.
- `mem_addr`  out  ADDR_W  word-aligned byte address; low 2 bits always 0.
- `mem_rdata`  in  32  read data, valid the cycle after `mem_en`.
  - Byte at the lowest address is in bits [7:0].
- `out_data`  out  32  lane1=[7:0] … lane4=[31:24]; lane1 is the leftmost pixel.
- `out_valid`  out  1  drives conv `rvalid`.
- `out_ready`  in  1  consumer accept.
- `win_last`  out  1  qualifies `out_valid`; marks the 3rd (top-row) word of a window.

## Operation
- **Counters**
  - `rb` = row band, 0..IMG_H-3 (outermost).
  - `wc` = window column, 0..(IMG_W-4)/2.
  - `ph` = phase, 0..2 (innermost).
- **Word address:** row = rb+2-ph; byte offset `off` = row·IMG_W + 2·wc; `A` = base_addr + off with bits [1:0] cleared.
  - Aligned when wc is even, unaligned when wc is odd.
- **FSM states:** IDLE, RDA, RDB, CAP, PUSH.
  - IDLE: `start` → RDA; latch base_addr; clear counters.
  - RDA: `mem_en`=1, `mem_addr`=A → RDB.
  - RDB: capture `mem_rdata` into LO.
    - Aligned: → PUSH with `out_data`=LO.
    - Unaligned: `mem_en`=1, `mem_addr`=A+4 → CAP.
  - CAP: capture HI; `out_data` = {HI[15:0], LO[31:16]} → PUSH.
  - PUSH: `out_valid`=1; `win_last` = (ph==2).
    - On `out_ready`, advance counters → RDA.
    - If this was the last word → IDLE with `done` pulse.
- **Counter wrap:** ph wraps 2→0 and increments wc; wc wraps at max and increments rb.
- **Word count:** total words = 3·(IMG_H-2)·((IMG_W-4)/2+1); 294 at defaults.
- **Masking:** `mem_en` is 0 outside RDA and RDB-unaligned; `mem_addr` is don't-care then.
- **Address arithmetic:** modulo 2^ADDR_W; wrap is not detected.
- **Stability:** `out_data` and `win_last` stay constant while `out_valid`=1 and `out_ready`=0.
- **`start` handling:** ignored while busy. `start` in the same cycle as `done` is ignored; it is accepted from IDLE one cycle later.

## Timing
- Reset values: busy, done, mem_en, out_valid, win_last = 0; mem_addr, out_data = 0; FSM to IDLE.
- Reset mid-operation aborts immediately; no `done` is produced.
- `start` is sampled at cycle 0. First `mem_en` is at cycle 1.
- First `out_valid` is at cycle 3 for an aligned word, cycle 4 for an unaligned word.
- Per-word cost with `out_ready`=1: 3 cycles aligned, 4 cycles unaligned.
- `done` rises the cycle after the final handshake; `busy` falls in the same cycle.

## Test plan
- **Reset:** assert reset_n=0 mid-run, including in CAP with out_valid=0.
  - All outputs go to 0 asynchronously.
  - After release, a new `start` yields the first word from the first address.
- **Small image, aligned and unaligned:** IMG_W=8, IMG_H=3, SRAM byte[a]=a, base 0, out_ready=1.
  - Words in order: 0x13121110, 0x0B0A0908, 0x03020100 (win_last), then 0x15141312, 0x0D0C0B0A, 0x05040302 (win_last), then 0x17161514, 0x0F0E0D0C, 0x07060504 (win_last).
  - `done` follows the 9th word.
- **Backpressure:** hold out_ready=0 for 5 cycles on the 2nd word.
  - out_data stays 0x0B0A0908 with out_valid=1.
  - No mem_en pulses while stalled.
- **Start handling:** pulse `start` while busy → ignored.
  - After `done`, start with base_addr=0x40 → first word 0x53525150 (IMG_W=8).
- **Default throughput:** IMG_W=16, IMG_H=16, out_ready=1.
  - 294 words, 98 win_last pulses.
  - Last handshake at cycle 1008; `done` at cycle 1009.
  - No mem_addr has bits [1:0] ≠ 0.

Source files
------------

// File: rtl/conv_feeder_if.sv
// Bus bundle for conv_feeder: SRAM read port plus the pixel-word stream to conv.
interface conv_feeder_if #(
  parameter int ADDR_W = 16
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              win_last;

  modport master (
    output mem_en, mem_addr, out_data, out_valid, win_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, out_data, out_valid, win_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/conv_feeder.sv
// conv_feeder: walks a signed 8-bit feature map in SRAM and streams 4-pixel
// words for the conv 3-row shift register, bottom row of each window first.
module conv_feeder #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  conv_feeder_if.master     bus
);

  localparam int WC_MAX = (IMG_W - 4) / 2;
  localparam int RB_MAX = IMG_H - 3;
  localparam int WC_W   = $clog2(IMG_W);
  localparam int RB_W   = $clog2(IMG_H);

  typedef enum logic [2:0] {IDLE, RDA, RDB, CAP, PUSH} state_t;

  state_t            state_q;
  logic [RB_W-1:0]   rb_q, rb_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [1:0]        ph_q, ph_d;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       lo_q;
  logic              busy_q, done_q, mem_en_q, out_valid_q, win_last_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       out_data_q;

  logic              last_word;
  logic [ADDR_W-1:0] addr_cur, addr_nxt, addr_first;

  // Word-aligned SRAM address of the word holding window (rb,wc) row phase ph.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] base,
    input logic [RB_W-1:0]   rb,
    input logic [WC_W-1:0]   wc,
    input logic [1:0]        ph
  );
    logic [ADDR_W-1:0] row, sum;
    row = ADDR_W'(rb) + ADDR_W'(2) - ADDR_W'(ph);
    sum = base + row * ADDR_W'(IMG_W) + (ADDR_W'(wc) << 1);
    return {sum[ADDR_W-1:2], 2'b00};
  endfunction

  // Next counter values and the addresses needed at each read launch.
  always_comb begin
    ph_d = ph_q;
    wc_d = wc_q;
    rb_d = rb_q;
    if (ph_q == 2'd2) begin
      ph_d = '0;
      if (wc_q == WC_W'(WC_MAX)) begin
        wc_d = '0;
        rb_d = rb_q + RB_W'(1);
      end else begin
        wc_d = wc_q + WC_W'(1);
      end
    end else begin
      ph_d = ph_q + 2'd1;
    end
    last_word  = (ph_q == 2'd2) && (wc_q == WC_W'(WC_MAX)) && (rb_q == RB_W'(RB_MAX));
    addr_cur   = word_addr(base_q, rb_q, wc_q, ph_q);
    addr_nxt   = word_addr(base_q, rb_d, wc_d, ph_d);
    addr_first = word_addr(base_addr, '0, '0, '0);
  end

  // Control FSM; every output is registered so reads launch the cycle after
  // the state decision that requests them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rb_q        <= '0;
      wc_q        <= '0;
      ph_q        <= '0;
      base_q      <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is not taken.
          if (start && !done_q) begin
            base_q     <= base_addr;
            rb_q       <= '0;
            wc_q       <= '0;
            ph_q       <= '0;
            busy_q     <= 1'b1;
            mem_en_q   <= 1'b1;
            mem_addr_q <= addr_first;
            state_q    <= RDA;
          end
        end
        RDA: begin
          // Odd columns straddle two words: fetch the following word too.
          mem_en_q   <= wc_q[0];
          mem_addr_q <= addr_cur + ADDR_W'(4);
          state_q    <= RDB;
        end
        RDB: begin
          lo_q <= bus.mem_rdata[31:16];
          if (!wc_q[0]) begin
            out_data_q  <= bus.mem_rdata;
            out_valid_q <= 1'b1;
            win_last_q  <= (ph_q == 2'd2);
            state_q     <= PUSH;
          end else begin
            mem_en_q <= 1'b0;
            state_q  <= CAP;
          end
        end
        CAP: begin
          out_data_q  <= {bus.mem_rdata[15:0], lo_q};
          out_valid_q <= 1'b1;
          win_last_q  <= (ph_q == 2'd2);
          state_q     <= PUSH;
        end
        PUSH: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            if (last_word) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              rb_q       <= rb_d;
              wc_q       <= wc_d;
              ph_q       <= ph_d;
              mem_en_q   <= 1'b1;
              mem_addr_q <= addr_nxt;
              state_q    <= RDA;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.win_last  = win_last_q;

endmodule
